// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the two writeback sources, the register file
// write port and the hazard query from control.
interface regfile_write_arbiter_if;
   logic        req0_valid;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        rf_write_en;
   logic [4:0]  rf_write_address;
   logic [31:0] rf_write_data;
   logic [4:0]  chk_addr;
   logic        chk_pending;

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready,
      input  rf_write_en, rf_write_address, rf_write_data,
      output chk_addr,
      input  chk_pending
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready,
      output rf_write_en, rf_write_address, rf_write_data,
      input  chk_addr,
      output chk_pending
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-source register file write arbiter: one-entry buffer per source,
// round-robin on contention, registered write port and hazard query.
module regfile_write_arbiter #(
   parameter bit DROP_R0 = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   regfile_write_arbiter_if.slave  bus
);

   logic        buf0_full, buf1_full;
   logic [4:0]  buf0_addr, buf1_addr;
   logic [31:0] buf0_data, buf1_data;
   logic        last_grant;   // 1: requester 1 was granted most recently
   logic        grant0, grant1, grant_any, drop;
   logic        load0, load1;
   logic [4:0]  grant_addr;
   logic [31:0] grant_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   always_comb begin
      grant0     = buf0_full & (~buf1_full | last_grant);
      grant1     = buf1_full & (~buf0_full | ~last_grant);
      grant_any  = grant0 | grant1;
      grant_addr = grant0 ? buf0_addr : buf1_addr;
      grant_data = grant0 ? buf0_data : buf1_data;
      drop       = DROP_R0 && (grant_addr == '0);
   end

   assign bus.req0_ready = ~buf0_full | grant0;
   assign bus.req1_ready = ~buf1_full | grant1;
   assign load0          = bus.req0_valid & bus.req0_ready;
   assign load1          = bus.req1_valid & bus.req1_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf0_full <= 1'b0;
         buf0_addr <= '0;
         buf0_data <= '0;
         buf1_full <= 1'b0;
         buf1_addr <= '0;
         buf1_data <= '0;
      end else begin
         if (load0) begin
            buf0_full <= 1'b1;
            buf0_addr <= bus.req0_addr;
            buf0_data <= bus.req0_data;
         end else if (grant0) begin
            buf0_full <= 1'b0;
         end
         if (load1) begin
            buf1_full <= 1'b1;
            buf1_addr <= bus.req1_addr;
            buf1_data <= bus.req1_data;
         end else if (grant1) begin
            buf1_full <= 1'b0;
         end
      end
   end

   // Dropped r0 grants leave address/data untouched so the port stays stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         last_grant <= 1'b1;
      end else begin
         wr_en <= grant_any & ~drop;
         if (grant_any & ~drop) begin
            wr_addr <= grant_addr;
            wr_data <= grant_data;
         end
         if (grant_any) begin
            last_grant <= grant1;
         end
      end
   end

   assign bus.rf_write_en      = wr_en;
   assign bus.rf_write_address = wr_addr;
   assign bus.rf_write_data    = wr_data;

   always_comb begin
      bus.chk_pending = (buf0_full && (buf0_addr == bus.chk_addr)) ||
                        (buf1_full && (buf1_addr == bus.chk_addr)) ||
                        (wr_en && (wr_addr == bus.chk_addr));
      if (DROP_R0 && (bus.chk_addr == '0)) begin
         bus.chk_pending = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios pinned with literal
// expectations, then random traffic checked against a pending-write model.
module tb_regfile_write_arbiter;

   localparam bit DROP = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_write_arbiter_if bus ();

   regfile_write_arbiter #(.DROP_R0(DROP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: each source has at most one pending write; on contention the
   // source that did not win last time goes first.
   bit          m_pend [2];
   logic [4:0]  m_addr [2];
   logic [31:0] m_data [2];
   int          m_last;
   bit          m_en;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   logic [31:0] dut_rf [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) m_pend[i] = 1'b0;
      m_last = 1;
      m_en   = 1'b0;
      m_wa   = '0;
      m_wd   = '0;
   endtask

   function automatic int model_winner();
      if (m_pend[0] && m_pend[1]) return (m_last == 0) ? 1 : 0;
      if (m_pend[0]) return 0;
      if (m_pend[1]) return 1;
      return -1;
   endfunction

   function automatic bit model_chk(input logic [4:0] a);
      if (DROP && a == 5'd0) return 1'b0;
      return (m_pend[0] && m_addr[0] == a) || (m_pend[1] && m_addr[1] == a) ||
             (m_en && m_wa == a);
   endfunction

   task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] ca);
      bus.req0_valid = v0;
      bus.req0_addr  = a0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_addr  = a1;
      bus.req1_data  = d1;
      bus.chk_addr   = ca;
   endtask

   task automatic idle(input logic [4:0] ca);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ca);
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      int g;
      bit rdy [2];
      bit v [2];
      logic [4:0]  a [2];
      logic [31:0] d [2];
      #1;
      g = model_winner();
      for (int i = 0; i < 2; i++) rdy[i] = !m_pend[i] || (g == i);
      check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, rdy[0]});
      check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, rdy[1]});
      check("chk_pending", {31'd0, bus.chk_pending}, {31'd0, model_chk(bus.chk_addr)});
      v[0] = bus.req0_valid; a[0] = bus.req0_addr; d[0] = bus.req0_data;
      v[1] = bus.req1_valid; a[1] = bus.req1_addr; d[1] = bus.req1_data;
      @(posedge clk);
      m_en = 1'b0;
      if (g >= 0) begin
         m_last = g;
         if (!(DROP && m_addr[g] == 5'd0)) begin
            m_en = 1'b1;
            m_wa = m_addr[g];
            m_wd = m_data[g];
         end
         m_pend[g] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         if (v[i] && rdy[i]) begin
            m_pend[i] = 1'b1;
            m_addr[i] = a[i];
            m_data[i] = d[i];
         end
      end
      @(negedge clk);
      check("rf_write_en", {31'd0, bus.rf_write_en}, {31'd0, m_en});
      check("rf_write_address", {27'd0, bus.rf_write_address}, {27'd0, m_wa});
      check("rf_write_data", bus.rf_write_data, m_wd);
      if (bus.rf_write_en) dut_rf[bus.rf_write_address] = bus.rf_write_data;
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < 32; i++) dut_rf[i] = '0;
      idle(5'd0);
      #3;
      check("reset_en", {31'd0, bus.rf_write_en}, 32'd0);
      check("reset_addr", {27'd0, bus.rf_write_address}, 32'd0);
      check("reset_data", bus.rf_write_data, 32'd0);
      check("reset_ready0", {31'd0, bus.req0_ready}, 32'd1);
      check("reset_ready1", {31'd0, bus.req1_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Tie straight after reset: requester 0 first, later write lands last.
      drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd0);
      step();
      idle(5'd0);
      step();
      check("tie_first_en", {31'd0, bus.rf_write_en}, 32'd1);
      check("tie_first_data", bus.rf_write_data, 32'h11);
      step();
      check("tie_second_data", bus.rf_write_data, 32'h22);
      check("tie_reg3", dut_rf[3], 32'h22);
      step();
      check("tie_done_en", {31'd0, bus.rf_write_en}, 32'd0);

      // Continuous contention: grants alternate 0,1,0,...
      for (int k = 1; k <= 8; k++) begin
         if (k <= 6)
            drive(1'b1, 5'd1, 32'hA000_0000 | k, 1'b1, 5'd2, 32'hB000_0000 | k, 5'd0);
         else
            idle(5'd0);
         if (k >= 2 && k <= 6) begin
            #1;
            check("alt_ready0", {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("alt_ready1", {31'd0, bus.req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
         end
         step();
         if (k >= 2) begin
            check("alt_en", {31'd0, bus.rf_write_en}, 32'd1);
            check("alt_src", {28'd0, bus.rf_write_data[31:28]}, (k % 2 == 0) ? 32'hA : 32'hB);
         end
      end
      idle(5'd0);
      step();

      // Single write latency.
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0);
      step();
      check("single_e0_en", {31'd0, bus.rf_write_en}, 32'd0);
      idle(5'd0);
      step();
      check("single_en", {31'd0, bus.rf_write_en}, 32'd1);
      check("single_addr", {27'd0, bus.rf_write_address}, 32'd5);
      check("single_data", bus.rf_write_data, 32'hDEADBEEF);
      step();
      check("single_after_en", {31'd0, bus.rf_write_en}, 32'd0);
      check("single_hold_data", bus.rf_write_data, 32'hDEADBEEF);

      // Writes to r0 are consumed but never issued.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0);
      #1;
      check("r0_ready1", {31'd0, bus.req1_ready}, 32'd1);
      step();
      idle(5'd0);
      #1;
      check("r0_chk", {31'd0, bus.chk_pending}, 32'd0);
      step();
      check("r0_en", {31'd0, bus.rf_write_en}, 32'd0);
      step();
      check("r0_en_later", {31'd0, bus.rf_write_en}, 32'd0);

      // Hazard query follows the write until its write cycle ends.
      drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 5'd9);
      step();
      idle(5'd9);
      #1;
      check("haz_buffered", {31'd0, bus.chk_pending}, 32'd1);
      step();
      #1;
      check("haz_writing", {31'd0, bus.chk_pending}, 32'd1);
      step();
      #1;
      check("haz_clear", {31'd0, bus.chk_pending}, 32'd0);

      // Reset between edges with both buffers occupied.
      drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 5'd7);
      step();
      step();
      check("mid_en_before", {31'd0, bus.rf_write_en}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_en_reset", {31'd0, bus.rf_write_en}, 32'd0);
      check("mid_ready0", {31'd0, bus.req0_ready}, 32'd1);
      check("mid_ready1", {31'd0, bus.req1_ready}, 32'd1);
      check("mid_chk", {31'd0, bus.chk_pending}, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      idle(5'd7);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("mid_no_replay", {31'd0, bus.rf_write_en}, 32'd0);
      end

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
